// File: rtl/tv_checker.sv
// ---------------------------------------------------------------------------
// tv_checker
// Test-vector engine. Holds up to DEPTH vectors {inputs, expected} and streams
// the inputs to a DUT, one per cycle. Each DUT response is compared after LAT
// cycles. The block reports the mismatch count, the first failing vector and
// an overall pass flag.
//
// Ports
//   clk, reset      clock; synchronous active-low reset
//   wr_en/addr/data vector memory write port ({inputs, expected}, inputs MSB)
//   vec_count       vectors to run (clamped to DEPTH), sampled on start
//   stop_on_err     end the run at the first mismatch, sampled on start
//   start           run request (accepted in IDLE or DONE)
//   dut_in          registered stimulus to the DUT
//   dut_out         DUT response
//   busy, done      run in progress / run finished (held until next start)
//   pass            done with zero mismatches
//   err_pulse       one cycle per detected mismatch
//   err_count       mismatches in this run
//   first_err_idx   index of first failing vector
//   first_err_got   DUT output at first failure
// ---------------------------------------------------------------------------
module tv_checker #(
   parameter  int IN_W  = 5,
   parameter  int OUT_W = 2,
   parameter  int DEPTH = 32,
   parameter  int LAT   = 0,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [IN_W+OUT_W-1:0] wr_data,
   input  logic [CW-1:0]         vec_count,
   input  logic                  stop_on_err,
   input  logic                  start,
   output logic [IN_W-1:0]       dut_in,
   input  logic [OUT_W-1:0]      dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  err_pulse,
   output logic [CW-1:0]         err_count,
   output logic [AW-1:0]         first_err_idx,
   output logic [OUT_W-1:0]      first_err_got
);

   localparam int VW = IN_W + OUT_W;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state;
   logic [VW-1:0]    mem [DEPTH];
   logic [CW-1:0]    n_run;
   logic [CW-1:0]    ptr;
   logic [CW-1:0]    n_clamp;
   logic             stop_mode;

   // expected value / index / valid travelling alongside each applied vector;
   // stage 0 belongs to the vector currently on dut_in, stage LAT is compared
   logic [OUT_W-1:0] pipe_exp [LAT+1];
   logic [AW-1:0]    pipe_idx [LAT+1];
   logic [LAT:0]     pipe_vld;

   logic             idle_like;
   logic             launch;
   logic             active;
   logic             cmp_fire;
   logic             mismatch;
   logic             last_cmp;
   logic             finish;
   logic             load_now;
   logic             wr_ok;
   logic [AW-1:0]    load_addr;
   logic [VW-1:0]    load_vec;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign n_clamp   = (vec_count > CW'(DEPTH)) ? CW'(DEPTH) : vec_count;
   assign launch    = idle_like && start && (n_clamp != '0);
   assign active    = (state == RUN) || (state == DRAIN);
   assign cmp_fire  = active && pipe_vld[LAT];
   assign mismatch  = cmp_fire && (dut_out != pipe_exp[LAT]);
   assign last_cmp  = cmp_fire && (CW'(pipe_idx[LAT]) == (n_run - CW'(1)));
   // a stop-mode mismatch ends the run; no further vector is launched then
   assign finish    = (mismatch && stop_mode) || last_cmp;
   assign load_now  = launch || ((state == RUN) && (ptr < n_run) && !finish);
   assign load_addr = idle_like ? '0 : ptr[AW-1:0];
   assign load_vec  = mem[load_addr];
   assign wr_ok     = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

   // vector memory: writable only while not running; a write coinciding with
   // start commits at the same edge, so the run sees the old contents
   always_ff @(posedge clk) begin
      if (wr_en && idle_like && wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // expected/index shift register (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (load_now) begin
         pipe_exp[0] <= load_vec[OUT_W-1:0];
         pipe_idx[0] <= load_addr;
      end
      for (int k = 1; k <= LAT; k++) begin
         pipe_exp[k] <= pipe_exp[k-1];
         pipe_idx[k] <= pipe_idx[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         n_run         <= '0;
         ptr           <= '0;
         stop_mode     <= 1'b0;
         pipe_vld      <= '0;
         dut_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_pulse     <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
      end else begin
         err_pulse   <= 1'b0;
         pipe_vld[0] <= load_now;
         for (int k = 1; k <= LAT; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
         end

         if (load_now) begin
            dut_in <= load_vec[VW-1:OUT_W];
            ptr    <= launch ? CW'(1) : ptr + CW'(1);
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  n_run         <= n_clamp;
                  stop_mode     <= stop_on_err;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  first_err_got <= '0;
                  if (n_clamp == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            RUN: begin
               // all vectors applied; wait for the pipeline to empty
               if (ptr == n_run) begin
                  state <= DRAIN;
               end
            end
            default: ;
         endcase

         if (mismatch) begin
            err_pulse <= 1'b1;
            err_count <= err_count + CW'(1);
            if (err_count == '0) begin
               first_err_idx <= pipe_idx[LAT];
               first_err_got <= dut_out;
            end
         end

         if (finish) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= !mismatch && (err_count == '0);
            pipe_vld <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tv_checker.sv
module tb_tv_checker;

   logic            clk = 1'b0;
   logic            reset;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [6:0]      wr_data;
   logic [5:0]      vec_count;
   logic            stop_on_err;
   logic [2:0]      start_v;
   logic [2:0][4:0] din;
   logic [2:0][1:0] dout;
   logic [2:0]      busy_a, done_a, pass_a, pulse_a;
   logic [2:0][5:0] cnt_a;
   logic [2:0][4:0] fidx_a;
   logic [2:0][1:0] fgot_a;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // reference DUT function: 2-bit sum of the input fields
   function automatic logic [1:0] f(input logic [4:0] x);
      return 2'(x[4:3] + x[2:1] + {1'b0, x[0]});
   endfunction

   // instance g uses checker latency g; DUT 0 is combinational, DUTs 1 and 2
   // are the same 2-stage registered DUT
   for (genvar g = 0; g < 3; g++) begin : g_inst
      tv_checker #(.IN_W(5), .OUT_W(2), .DEPTH(32), .LAT(g)) u_chk (
         .clk           (clk),
         .reset         (reset),
         .wr_en         (wr_en),
         .wr_addr       (wr_addr),
         .wr_data       (wr_data),
         .vec_count     (vec_count),
         .stop_on_err   (stop_on_err),
         .start         (start_v[g]),
         .dut_in        (din[g]),
         .dut_out       (dout[g]),
         .busy          (busy_a[g]),
         .done          (done_a[g]),
         .pass          (pass_a[g]),
         .err_pulse     (pulse_a[g]),
         .err_count     (cnt_a[g]),
         .first_err_idx (fidx_a[g]),
         .first_err_got (fgot_a[g])
      );
      if (g == 0) begin : g_comb
         assign dout[g] = f(din[g]);
      end else begin : g_reg
         logic [1:0] r1, r2;
         always_ff @(posedge clk) begin
            r1 <= f(din[g]);
            r2 <= r1;
         end
         assign dout[g] = r2;
      end
   end

   // bench copy of vector memory and reference-model results
   logic [6:0] tmem [32];
   int m_done, m_errs, m_first, m_got, m_pass;
   bit m_pulse [256];

   task automatic cmp(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wr_vec(input int a, input logic [6:0] d);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = d;
      tmem[a] = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic load_clean();
      for (int i = 0; i < 32; i++) wr_vec(i, {5'(i), f(5'(i))});
   endtask

   // behavioural model: which vectors fail, when the run ends, when pulses occur
   task automatic model(input int n, input int stop, input int lat);
      int  nn;
      bit  stopped;
      logic [4:0] x;
      nn = (n > 32) ? 32 : n;
      m_errs = 0; m_first = 0; m_got = 0; stopped = 0;
      foreach (m_pulse[c]) m_pulse[c] = 0;
      for (int i = 0; i < nn; i++) begin
         x = tmem[i][6:2];
         if (!stopped && f(x) != tmem[i][1:0]) begin
            if (m_errs == 0) begin
               m_first = i;
               m_got   = f(x);
            end
            m_errs++;
            m_pulse[i + lat + 2] = 1;
            if (stop != 0) begin
               stopped = 1;
               m_done  = i + lat + 2;
            end
         end
      end
      if (!stopped) m_done = (nn == 0) ? 1 : nn + lat + 1;
      m_pass = (m_errs == 0) ? 1 : 0;
   endtask

   // runs one vector pass on instance sel; wr_at: -1 none, 0 with start, k in cycle k
   task automatic do_run(input int sel, input int n, input int stop, input int wr_at,
                         input logic [4:0] wa, input logic [6:0] wd,
                         output int r_done, output int pulse_bad, output int busy_bad);
      int cyc;
      vec_count    = 6'(n);
      stop_on_err  = (stop != 0);
      start_v[sel] = 1'b1;
      if (wr_at == 0) begin
         wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      @(posedge clk); #1;
      start_v = '0;
      wr_en   = 1'b0;
      cyc = 1; pulse_bad = 0; busy_bad = 0; r_done = -1;
      while (cyc <= 200) begin
         if (cyc == wr_at) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
         end
         if (pulse_a[sel] != m_pulse[cyc]) pulse_bad++;
         if (done_a[sel]) begin
            r_done = cyc;
            break;
         end
         if (!busy_a[sel]) busy_bad++;
         @(posedge clk); #1;
         wr_en = 1'b0;
         cyc++;
      end
      wr_en = 1'b0;
      if (busy_a[sel]) busy_bad++;
   endtask

   // e_* < 0 means "take the reference model's value"
   task automatic run_check(input string name, input int sel, input int n, input int stop,
                            input int wr_at, input logic [4:0] wa, input logic [6:0] wd,
                            input int e_done, input int e_errs, input int e_first, input int e_pass);
      int r_done, pb, bb, nn;
      model(n, stop, sel);
      do_run(sel, n, stop, wr_at, wa, wd, r_done, pb, bb);
      nn = (n > 32) ? 32 : n;
      cmp({name, " done_cycle"}, r_done, (e_done < 0) ? m_done : e_done);
      cmp({name, " err_count"}, int'(cnt_a[sel]), (e_errs < 0) ? m_errs : e_errs);
      cmp({name, " first_idx"}, int'(fidx_a[sel]), (e_first < 0) ? m_first : e_first);
      cmp({name, " first_got"}, int'(fgot_a[sel]), m_got);
      cmp({name, " pass"}, int'(pass_a[sel]), (e_pass < 0) ? m_pass : e_pass);
      cmp({name, " pulses"}, pb, 0);
      cmp({name, " busy"}, bb, 0);
      if (nn > 0 && !(stop != 0 && m_errs > 0))
         cmp({name, " dut_in_hold"}, int'(din[sel]), int'(tmem[nn-1][6:2]));
   endtask

   typedef struct {
      string name;
      int sel, n, stop, bad0, bad1;
      int e_done, e_errs, e_first, e_pass;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [4:0] rx;
      logic [1:0] re;
      int r_done, pb, bb;

      tbl[0] = '{"clean32",    0, 32, 0, -1, -1, 33, 0,  0, 1};
      tbl[1] = '{"bad7_20",    0, 32, 0,  7, 20, 33, 2,  7, 0};
      tbl[2] = '{"stop3",      0, 32, 1,  3, -1,  5, 1,  3, 0};
      tbl[3] = '{"n0",         0,  0, 0, -1, -1,  1, 0,  0, 1};
      tbl[4] = '{"n40",        0, 40, 0, -1, -1, 33, 0,  0, 1};
      tbl[5] = '{"lat2_n10",   2, 10, 0, -1, -1, 13, 0,  0, 1};
      tbl[6] = '{"lat2_bad4",  2, 10, 0,  4, -1, 13, 1,  4, 0};
      tbl[7] = '{"lat2_stop",  2, 32, 1, 10, -1, 14, 1, 10, 0};
      tbl[8] = '{"stop_last",  0, 32, 1, 31, -1, 33, 1, 31, 0};
      tbl[9] = '{"n1",         0,  1, 0, -1, -1,  2, 0,  0, 1};

      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      vec_count = '0; stop_on_err = 1'b0; start_v = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++)
         cmp("reset_state", int'({din[g], busy_a[g], done_a[g], pass_a[g], pulse_a[g],
                                  cnt_a[g], fidx_a[g], fgot_a[g]}), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < 10; t++) begin
         load_clean();
         if (tbl[t].bad0 >= 0)
            wr_vec(tbl[t].bad0, tmem[tbl[t].bad0] ^ 7'd1);
         if (tbl[t].bad1 >= 0)
            wr_vec(tbl[t].bad1, tmem[tbl[t].bad1] ^ 7'd1);
         run_check(tbl[t].name, tbl[t].sel, tbl[t].n, tbl[t].stop, -1, '0, '0,
                   tbl[t].e_done, tbl[t].e_errs, tbl[t].e_first, tbl[t].e_pass);
      end

      // latency misconfigured against a 2-stage DUT must report mismatches
      load_clean();
      model(32, 0, 1);
      do_run(1, 32, 0, -1, '0, '0, r_done, pb, bb);
      cmp("lat1_done_cycle", r_done, 34);
      cmp("lat1_has_errors", (cnt_a[1] != 0) ? 1 : 0, 1);

      // write while busy must be ignored
      load_clean();
      run_check("busy_write", 0, 32, 0, 3, 5'd5, {5'd5, ~f(5'd5)}, 33, 0, 0, 1);

      // start and write together in DONE: run sees old contents
      run_check("start_write", 0, 32, 0, 0, 5'd0, {5'd0, f(5'd0) ^ 2'd1}, 33, 0, 0, 1);
      tmem[0] = {5'd0, f(5'd0) ^ 2'd1};
      run_check("after_write", 0, 32, 0, -1, '0, '0, 33, 1, 0, 0);

      // reset in cycle 5 aborts the run; restart reproduces a full run
      load_clean();
      wr_vec(7, tmem[7] ^ 7'd1);
      vec_count   = 6'd32;
      stop_on_err = 1'b0;
      start_v[0]  = 1'b1;
      @(posedge clk); #1;
      start_v = '0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      cmp("mid_reset_outputs", int'({din[0], busy_a[0], done_a[0], pass_a[0], pulse_a[0],
                                     cnt_a[0], fidx_a[0], fgot_a[0]}), 0);
      run_check("restart", 0, 32, 0, -1, '0, '0, 33, 1, 7, 0);

      // randomized memories and run settings against the model
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 32; i++) begin
            rx = 5'($urandom);
            re = f(rx);
            if ($urandom_range(0, 7) == 0) re = re ^ 2'($urandom_range(1, 3));
            wr_vec(i, {rx, re});
         end
         run_check("random", 2 * int'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 1)), -1, '0, '0, -1, -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tv_checker.md
# tv_checker

Synthesizable, parametrised test-vector engine for self-checking on-chip or bench use. Holds up to DEPTH stored vectors of the form {inputs, expected outputs} and streams them into a device under test (DUT) at one vector per cycle. It compares the DUT response after a configurable latency and reports the error count, the first failing vector, and pass/fail. It generalises the team's per-block vector benches to arbitrary I/O widths, pipelined DUTs, and a stop-on-first-error mode.

## Interface
- IN_W, 5, DUT input width
- OUT_W, 2, DUT output width
- DEPTH, 32, vector memory depth (≥1)
- LAT, 0, DUT latency in cycles (0 = combinational DUT)
- CW = $clog2(DEPTH+1), derived count width
- AW = $clog2(DEPTH), derived address width (minimum 1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- wr_en  in  1  vector memory write strobe
- wr_addr  in  AW  vector write address
- wr_data  in  IN_W+OUT_W  vector, {inputs, expected}, inputs in MSBs
- vec_count  in  CW  number of vectors to run, sampled on start
- stop_on_err  in  1  mode, sampled on start
- start  in  1  run request, 1-cycle pulse or level
- dut_in  out  IN_W  registered stimulus to DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done && err_count==0
- err_pulse  out  1  one cycle per detected mismatch
- err_count  out  CW  mismatches this run
- first_err_idx  out  AW  index of first failing vector
- first_err_got  out  OUT_W  DUT output at first failure

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (reset==0 at a clk edge) has the following effects:
  - It forces IDLE and zeroes all outputs: dut_in=0, busy=0, done=0, pass=0, err_pulse=0, err_count=0, first_err_idx=0, first_err_got=0.
  - It also flushes the expected-value pipeline.
  - Vector memory is not cleared.
  - Reset mid-run aborts the run immediately.
- Writes:
  - Accepted in IDLE and DONE only; ignored while busy.
  - Write to address ≥ DEPTH is ignored.
- start from IDLE or DONE:
  - Latches vec_count (N) and stop_on_err.
  - Clears err_count, first_err_*, done, and pass.
  - Enters RUN.
  - start while busy is ignored.
- N==0: RUN is skipped. Go directly to DONE next cycle with pass=1.
- N>DEPTH: clamped to DEPTH.
- RUN: presents vector i on dut_in in cycle i (i=0..N-1). The expected field travels through a LAT-stage shift register alongside a valid bit and the index.
- DRAIN: entered after the last vector is applied; lasts LAT cycles.
  - dut_in holds the last vector throughout DRAIN and DONE.
- Compare: at the clk edge where the expected value for vector i emerges from the pipeline, dut_out != expected counts as a mismatch. A mismatch has these effects:
  - err_pulse=1 for the following cycle.
  - err_count increments.
  - If it is the first mismatch, first_err_idx=i and first_err_got=dut_out are captured.
- stop_on_err=1: the first mismatch moves the block to DONE.
  - In-flight vectors are discarded, not compared.
  - Final err_count=1.
- DONE: busy=0, done=1, pass=(err_count==0). Held until start or reset.

## Timing
- start sampled at edge E0. Vector i is on dut_in during cycle i+1, i.e. after edge E0+i.
- Vector i response is sampled at edge E0+1+i+LAT.
- err_pulse, err_count, and first_err_* for vector i are visible in the cycle after edge E0+1+i+LAT.
- busy=1 from cycle 1 through cycle N+LAT.
- done=1 from cycle N+LAT+1.
- Total latency start→done is N+LAT+1 cycles. Throughput is 1 vector/cycle.
- Stop mode, mismatch sampled at edge Ek: done=1 and busy=0 in the cycle after Ek.
- Simultaneous start and wr_en in DONE: both take effect. The run uses the memory contents before the write, since the write commits at the same edge.

## Test plan
- Defaults, 32 vectors of addac-style 5-in/2-out truth table written to a matching DUT, vec_count=32, start → done in cycle 33, err_count=0, pass=1, err_pulse never high.
- Same run with the expected field of vector 7 corrupted, plus vector 20 corrupted → err_pulse in cycles 9 and 22, err_count=2, first_err_idx=7, first_err_got=true DUT value, pass=0.
- LAT=2 with a 2-stage registered DUT, vec_count=10, all correct → done in cycle 13, pass=1. The same stimulus with LAT=1 mismatches the DUT → err_count>0.
- stop_on_err=1, vector 3 wrong → done in cycle 5, err_count=1, first_err_idx=3. Vectors 4+ are not counted.
- vec_count=0 → done next cycle, pass=1. vec_count=40 with DEPTH=32 → runs 32 vectors.
- Reset asserted in cycle 5 of a run → next cycle all outputs 0 and state IDLE. Restart without rewriting memory → identical results to an uninterrupted run.
